// File: rtl/vector_register_file_pipelined_pkg.sv
// Shared constants for the pipelined vector register file.
//   VECTOR_RF_WRITE : rf_signal encoding that requests a register write
//   RF_NOP          : rf_status idle value
//   RF_FINISHED     : rf_status value for the cycle after a pending write commits
//   VRF_NUM_REGS    : architectural vector register count
package vector_register_file_pipelined_pkg;

    localparam logic [1:0] VECTOR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_NOP          = 2'b00;
    localparam logic [1:0] RF_FINISHED     = 2'b01;
    localparam int         VRF_NUM_REGS    = 32;
    localparam int         VRF_IDX_W       = $clog2(VRF_NUM_REGS);

endpackage

// File: rtl/vector_register_file_pipelined_write_merge.sv
// vrf_write_merge: combinational element-granular merge for a vector write.
// Element i takes new data when start <= i < min(length, VECTOR_SIZE) and the
// element is unmasked (vm=1, or mask bit i set); otherwise it keeps old_vec.
// Ports:
//   old_vec  in   current destination contents (already including any pending write)
//   data     in   write data, element i at [i*LEN +: LEN]
//   start    in   first element written
//   length   in   one past last element written (clamped to VECTOR_SIZE)
//   vm       in   1 = ignore mask
//   mask     in   bit i = bit 0 of v0 element i
//   merged   out  resulting vector
module vrf_write_merge #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic [VECTOR_SIZE*LEN-1:0]  old_vec,
    input  logic [VECTOR_SIZE*LEN-1:0]  data,
    input  logic [ENTRY_INDEX_SIZE-1:0] start,
    input  logic [ENTRY_INDEX_SIZE:0]   length,
    input  logic                        vm,
    input  logic [VECTOR_SIZE-1:0]      mask,
    output logic [VECTOR_SIZE*LEN-1:0]  merged
);

    localparam logic [ENTRY_INDEX_SIZE:0] VS_L = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);

    logic [ENTRY_INDEX_SIZE:0] lim;
    logic [VECTOR_SIZE-1:0]    en;

    // length is one bit wider than an element index, so it can exceed the
    // register size; anything past the end is simply not written.
    assign lim = (length > VS_L) ? VS_L : length;

    for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_elem
        localparam logic [ENTRY_INDEX_SIZE:0] IDX = (ENTRY_INDEX_SIZE+1)'(gi);
        assign en[gi] = ({1'b0, start} <= IDX) && (IDX < lim) && (vm || mask[gi]);
        assign merged[gi*LEN +: LEN] = en[gi] ? data[gi*LEN +: LEN] : old_vec[gi*LEN +: LEN];
    end

endmodule

// File: rtl/vector_register_file_pipelined.sv
// vector_register_file_pipelined: 32 x (VECTOR_SIZE x LEN) vector register file.
// Three latched read ports plus a v0 mask view; element-granular masked writes
// retire through a one-entry pending stage (accept edge N, commit edge N+1).
// Optional build macro: VRF_BYPASS_EN -- reads and mask_data forward the pending
// vector when it targets the register being read.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy_in               global enable; low freezes all state
//   rf_signal            VECTOR_RF_WRITE requests a write; anything else is a null request
//   rs1, rs2, rs3, rd    read / write register indices
//   data, start, length  write data and element window [start, length)
//   vm                   1 = unmasked write; 0 = gated by v0 element bit 0
//   write_back_enabled   write-back request valid
//   rs1/2/3_data         read data from latched indices
//   mask_data            bit i = bit 0 of v0 element i
//   rf_status            RF_FINISHED for one cycle after a commit, else RF_NOP
//   busy                 pending write not yet committed
module vector_register_file_pipelined #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy_in,
    input  logic [1:0]                  rf_signal,
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    input  logic [4:0]                  rs3,
    input  logic [4:0]                  rd,
    input  logic [VECTOR_SIZE*LEN-1:0]  data,
    input  logic [ENTRY_INDEX_SIZE-1:0] start,
    input  logic [ENTRY_INDEX_SIZE:0]   length,
    input  logic                        vm,
    input  logic                        write_back_enabled,
    output logic [VECTOR_SIZE*LEN-1:0]  rs1_data,
    output logic [VECTOR_SIZE*LEN-1:0]  rs2_data,
    output logic [VECTOR_SIZE*LEN-1:0]  rs3_data,
    output logic [VECTOR_SIZE-1:0]      mask_data,
    output logic [1:0]                  rf_status,
    output logic                        busy
);
    import vector_register_file_pipelined_pkg::*;

    localparam int VW = VECTOR_SIZE * LEN;

    logic [VW-1:0]          regs_q [VRF_NUM_REGS];
    logic [VW-1:0]          regs_d [VRF_NUM_REGS];
    logic [VRF_IDX_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   pend_wr_q, pend_wr_d;     // 0 = null request, commits nothing
    logic [VRF_IDX_W-1:0]   pend_rd_q, pend_rd_d;
    logic [VW-1:0]          pend_data_q, pend_data_d;
    logic [1:0]             status_q, status_d;

    logic                   pend_live;
    logic                   rd_hit, v0_hit;
    logic [VW-1:0]          old_vec, merged;
    logic [VECTOR_SIZE-1:0] mask_eff;

    // The accept path always sees the pending write, independent of the read
    // bypass option, so back-to-back merges into the same register compose.
    assign pend_live = pend_vld_q && pend_wr_q;
    assign rd_hit    = pend_live && (pend_rd_q == rd);
    assign v0_hit    = pend_live && (pend_rd_q == '0);
    assign old_vec   = rd_hit ? pend_data_q : regs_q[rd];

    for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_mask
        assign mask_eff[gi] = v0_hit ? pend_data_q[gi*LEN] : regs_q[0][gi*LEN];
`ifdef VRF_BYPASS_EN
        assign mask_data[gi] = mask_eff[gi];
`else
        assign mask_data[gi] = regs_q[0][gi*LEN];
`endif
    end

    vrf_write_merge #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
    ) u_merge (
        .old_vec (old_vec),
        .data    (data),
        .start   (start),
        .length  (length),
        .vm      (vm),
        .mask    (mask_eff),
        .merged  (merged)
    );

    always_comb begin
        regs_d      = regs_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs3_d       = rs3_q;
        pend_vld_d  = pend_vld_q;
        pend_wr_d   = pend_wr_q;
        pend_rd_d   = pend_rd_q;
        pend_data_d = pend_data_q;
        status_d    = status_q;
        if (rdy_in) begin
            rs1_d    = rs1;
            rs2_d    = rs2;
            rs3_d    = rs3;
            status_d = pend_vld_q ? RF_FINISHED : RF_NOP;
            if (pend_live) regs_d[pend_rd_q] = pend_data_q;
            // Commit of the old entry and accept of a new one share this edge.
            pend_vld_d = write_back_enabled;
            if (write_back_enabled) begin
                pend_wr_d   = (rf_signal == VECTOR_RF_WRITE);
                pend_rd_d   = rd;
                pend_data_d = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VRF_NUM_REGS; i++) regs_q[i] <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs3_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_rd_q   <= '0;
            pend_data_q <= '0;
            status_q    <= RF_NOP;
        end else begin
            for (int i = 0; i < VRF_NUM_REGS; i++) regs_q[i] <= regs_d[i];
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs3_q       <= rs3_d;
            pend_vld_q  <= pend_vld_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            pend_data_q <= pend_data_d;
            status_q    <= status_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_q];
        rs2_data = regs_q[rs2_q];
        rs3_data = regs_q[rs3_q];
`ifdef VRF_BYPASS_EN
        if (pend_live && (pend_rd_q == rs1_q)) rs1_data = pend_data_q;
        if (pend_live && (pend_rd_q == rs2_q)) rs2_data = pend_data_q;
        if (pend_live && (pend_rd_q == rs3_q)) rs3_data = pend_data_q;
`endif
    end

    assign rf_status = status_q;
    assign busy      = pend_vld_q;

endmodule

// File: tb/tb_vector_register_file_pipelined.sv
// Self-checking bench for vector_register_file_pipelined. A reference model of
// the register array is updated when a request is accepted; each accepted
// request pushes its expected destination vector to a queue that is popped on
// RF_FINISHED and read back through rs3.
module tb_vector_register_file_pipelined;
    import vector_register_file_pipelined_pkg::*;

    localparam int LEN = 32;
    localparam int VS  = 8;
    localparam int EIS = 3;
    localparam int VW  = LEN * VS;

    typedef logic [VW-1:0] vec_t;
    typedef struct { logic [4:0] rd; vec_t vec; } sb_t;
    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  st;
        logic [3:0]  ln;
        logic        vm;
        logic        wr;
        logic [31:0] base;
        logic [31:0] step;
        logic        exp_busy;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst, rdy_in, vm, write_back_enabled;
    logic [1:0]     rf_signal;
    logic [4:0]     rs1, rs2, rs3, rd;
    vec_t           data;
    logic [EIS-1:0] start;
    logic [EIS:0]   length;
    vec_t           rs1_data, rs2_data, rs3_data;
    logic [VS-1:0]  mask_data;
    logic [1:0]     rf_status;
    logic           busy;

    vector_register_file_pipelined #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .rf_signal(rf_signal),
        .rs1(rs1), .rs2(rs2), .rs3(rs3), .rd(rd), .data(data),
        .start(start), .length(length), .vm(vm),
        .write_back_enabled(write_back_enabled),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data),
        .mask_data(mask_data), .rf_status(rf_status), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t model [32];
    sb_t  sbq[$];
    logic armed = 1'b0;
    vec_t armed_vec;

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t fill(input logic [31:0] base, input logic [31:0] step);
        vec_t v;
        for (int i = 0; i < VS; i++) v[i*LEN +: LEN] = base + 32'(i >> 1) * step;
        return v;
    endfunction

    function automatic logic [VS-1:0] model_mask();
        logic [VS-1:0] m;
        for (int i = 0; i < VS; i++) m[i] = model[0][i*LEN];
        return m;
    endfunction

    function automatic vec_t ref_merge(input vec_t old, input vec_t d, input int s, input int l,
                                       input logic v, input logic [VS-1:0] m);
        vec_t r = old;
        int lim = (l > VS) ? VS : l;
        for (int i = 0; i < VS; i++)
            if (i >= s && i < lim && (v || m[i])) r[i*LEN +: LEN] = d[i*LEN +: LEN];
        return r;
    endfunction

    // Drive one request for the coming edge and record what it must produce.
    task automatic drive_wr(input logic [4:0] r, input vec_t d, input logic [2:0] s,
                            input logic [3:0] l, input logic v, input logic w);
        sb_t e;
        rd = r; data = d; start = s; length = l; vm = v;
        rf_signal = w ? VECTOR_RF_WRITE : 2'b10;
        write_back_enabled = 1'b1;
        if (w) model[r] = ref_merge(model[r], d, int'(s), int'(l), v, model_mask());
        e.rd = r; e.vec = model[r];
        sbq.push_back(e);
    endtask

    // One clock; scoreboard bookkeeping only on enabled, non-reset edges.
    task automatic tick();
        logic en;
        sb_t  e;
        en = rdy_in && !rst;
        @(posedge clk);
        #1;
        if (en) begin
            if (armed) begin
                chk("sb_readback", rs3_data, armed_vec);
                armed = 1'b0;
            end
            if (rf_status == RF_FINISHED) begin
                n_chk++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_finished: got finished with empty queue, want none");
                end else begin
                    e = sbq.pop_front();
                    // A later write to the same register supersedes this one.
                    if (sbq.size() == 0 || sbq[0].rd != e.rd) begin
                        rs3 = e.rd; armed = 1'b1; armed_vec = e.vec;
                    end
                end
            end
        end
    endtask

    rec_t tbl [9];
    vec_t exp_v;

    initial begin
        tbl[0] = '{rd:5'd12, st:3'd0, ln:4'd8,  vm:1'b1, wr:1'b1, base:32'h1000_0000, step:32'h0101_0101, exp_busy:1'b1};
        tbl[1] = '{rd:5'd12, st:3'd2, ln:4'd5,  vm:1'b1, wr:1'b1, base:32'hCAFE_0000, step:32'h0000_0011, exp_busy:1'b1};
        tbl[2] = '{rd:5'd13, st:3'd0, ln:4'd15, vm:1'b1, wr:1'b1, base:32'h0BAD_F00D, step:32'h1111_0000, exp_busy:1'b1};
        tbl[3] = '{rd:5'd14, st:3'd5, ln:4'd3,  vm:1'b1, wr:1'b1, base:32'hFFFF_FFFF, step:32'h0000_0001, exp_busy:1'b1};
        tbl[4] = '{rd:5'd15, st:3'd0, ln:4'd8,  vm:1'b0, wr:1'b1, base:32'h5555_0000, step:32'h0000_0100, exp_busy:1'b1};
        tbl[5] = '{rd:5'd0,  st:3'd0, ln:4'd8,  vm:1'b0, wr:1'b1, base:32'h0000_0001, step:32'h0000_0001, exp_busy:1'b1};
        tbl[6] = '{rd:5'd16, st:3'd1, ln:4'd7,  vm:1'b0, wr:1'b1, base:32'h7777_0000, step:32'h0000_0003, exp_busy:1'b1};
        tbl[7] = '{rd:5'd12, st:3'd0, ln:4'd8,  vm:1'b1, wr:1'b0, base:32'hDEAD_BEEF, step:32'h0000_0001, exp_busy:1'b1};
        tbl[8] = '{rd:5'd31, st:3'd7, ln:4'd8,  vm:1'b1, wr:1'b1, base:32'h0123_4567, step:32'h0000_0000, exp_busy:1'b1};

        rst = 1'b1; rdy_in = 1'b1; vm = 1'b1; write_back_enabled = 1'b0;
        rf_signal = RF_NOP; rs1 = '0; rs2 = '0; rs3 = '0; rd = '0;
        data = '0; start = '0; length = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        tick(); tick();
        chk("rst_status", vec_t'(rf_status), vec_t'(RF_NOP));
        chk("rst_busy", vec_t'(busy), '0);
        chk("rst_rs1_idx0", rs1_data, '0);
        rst = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
        tick();
        chk("rd5_zero", rs1_data, '0);
        chk("rd31_zero", rs2_data, '0);
        chk("mask_zero", vec_t'(mask_data), '0);

        // Full write to v3, elements 1..8, with status timing
        for (int i = 0; i < VS; i++) exp_v[i*LEN +: LEN] = 32'(i + 1);
        drive_wr(5'd3, exp_v, 3'd0, 4'd8, 1'b1, 1'b1);
        tick();
        chk("w3_busy_after_accept", vec_t'(busy), vec_t'(1'b1));
        chk("w3_nop_after_accept", vec_t'(rf_status), vec_t'(RF_NOP));
        write_back_enabled = 1'b0;
        tick();
        chk("w3_finished", vec_t'(rf_status), vec_t'(RF_FINISHED));
        chk("w3_busy_clear", vec_t'(busy), '0);
        rs1 = 5'd3;
        tick();
        chk("w3_status_back_nop", vec_t'(rf_status), vec_t'(RF_NOP));
        chk("w3_readback", rs1_data, exp_v);

        // v0 = 1,0,1,0,...; masked windowed write to v4
        for (int i = 0; i < VS; i++) exp_v[i*LEN +: LEN] = 32'((i + 1) % 2);
        drive_wr(5'd0, exp_v, 3'd0, 4'd8, 1'b1, 1'b1);
        tick(); write_back_enabled = 1'b0; tick();
        chk("v0_mask", vec_t'(mask_data), vec_t'(8'h55));
        drive_wr(5'd4, {VS{32'hAA}}, 3'd1, 4'd6, 1'b0, 1'b1);
        tick(); write_back_enabled = 1'b0; tick();
        rs1 = 5'd4;
        tick();
        exp_v = '0; exp_v[2*LEN +: LEN] = 32'hAA; exp_v[4*LEN +: LEN] = 32'hAA;
        chk("v4_masked", rs1_data, exp_v);

        // Back-to-back writes to v7
        drive_wr(5'd7, {VS{32'h11}}, 3'd0, 4'd4, 1'b1, 1'b1);
        tick();
        drive_wr(5'd7, {VS{32'h22}}, 3'd4, 4'd8, 1'b1, 1'b1);
        rs1 = 5'd7;
        tick();
        chk("b2b_first_finished", vec_t'(rf_status), vec_t'(RF_FINISHED));
`ifdef VRF_BYPASS_EN
        exp_v = {{4{32'h22}}, {4{32'h11}}};
`else
        exp_v = {{4{32'h0}}, {4{32'h11}}};
`endif
        chk("b2b_read_during_pending", rs1_data, exp_v);
        write_back_enabled = 1'b0;
        tick();
        chk("b2b_second_finished", vec_t'(rf_status), vec_t'(RF_FINISHED));
        tick();
        chk("b2b_status_nop", vec_t'(rf_status), vec_t'(RF_NOP));
        chk("b2b_v7", rs1_data, {{4{32'h22}}, {4{32'h11}}});

        // Reset discards a pending write to v9
        drive_wr(5'd9, {VS{32'h99}}, 3'd0, 4'd8, 1'b1, 1'b1);
        tick();
        rst = 1'b1; write_back_enabled = 1'b0;
        sbq.delete(); armed = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        chk("rst_pending_busy", vec_t'(busy), '0);
        chk("rst_pending_status", vec_t'(rf_status), vec_t'(RF_NOP));
        rst = 1'b0; rs1 = 5'd9;
        tick();
        chk("rst_pending_no_finish", vec_t'(rf_status), vec_t'(RF_NOP));
        chk("rst_pending_v9_zero", rs1_data, '0);

        // rdy_in low for three cycles between accept and commit
        exp_v = fill(32'hA5A5_0000, 32'h0000_1111);
        drive_wr(5'd10, exp_v, 3'd0, 4'd8, 1'b1, 1'b1);
        tick();
        rdy_in = 1'b0; write_back_enabled = 1'b0; rs1 = 5'd10;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("freeze_busy", vec_t'(busy), vec_t'(1'b1));
            chk("freeze_status", vec_t'(rf_status), vec_t'(RF_NOP));
        end
        chk("freeze_idx_held", rs1_data, '0);
        rdy_in = 1'b1;
        tick();
        chk("freeze_commit_finished", vec_t'(rf_status), vec_t'(RF_FINISHED));
        tick();
        chk("freeze_data", rs1_data, exp_v);

        // Table of assorted requests, each followed by two idle cycles so the
        // scoreboard readback sees a settled array.
        for (int k = 0; k < 9; k++) begin
            drive_wr(tbl[k].rd, fill(tbl[k].base, tbl[k].step), tbl[k].st, tbl[k].ln, tbl[k].vm, tbl[k].wr);
            tick();
            chk($sformatf("tbl%0d_busy", k), vec_t'(busy), vec_t'(tbl[k].exp_busy));
            write_back_enabled = 1'b0;
            tick(); tick();
        end
        chk("tbl_mask_final", vec_t'(mask_data), vec_t'(model_mask()));
        rs1 = 5'd12; rs2 = 5'd14;
        tick();
        chk("tbl_v12", rs1_data, model[12]);
        chk("tbl_v14_untouched", rs2_data, '0);

        tick(); tick(); tick();
        chk("sb_drained", vec_t'(sbq.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_register_file_pipelined.md
# vector_register_file_pipelined

Parametrised vector register file with 32 registers of VECTOR_SIZE elements × LEN bits, serving the vector decode stage (three operand reads plus a v0 mask read) and the vector write-back stage. Writes are element-granular (vstart..length window, optional v0 masking) and retire through a one-entry pending-write stage with handshake status. It replaces the single-write, unmasked register file in the vector datapath.

## Interface
- LEN, 32, element width in bits
- VECTOR_SIZE, 8, elements per register
- ENTRY_INDEX_SIZE, 3, element index width; must equal $clog2(VECTOR_SIZE)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes all state
- rf_signal  in  2  `VECTOR_RF_WRITE` requests a write; other values never write
- rs1, rs2, rs3  in  5  read indices (rs3 = accumulator/old-vd source)
- rd  in  5  write index
- data  in  VECTOR_SIZE*LEN  write data, element i at [i*LEN +: LEN]
- start  in  ENTRY_INDEX_SIZE  first element written (vstart)
- length  in  ENTRY_INDEX_SIZE+1  one past last element written (0..VECTOR_SIZE)
- vm  in  1  1 = unmasked; 0 = element i written only if v0 element i bit 0 is 1
- write_back_enabled  in  1  write-back request valid
- rs1_data, rs2_data, rs3_data  out  VECTOR_SIZE*LEN  read data
- mask_data  out  VECTOR_SIZE  bit i = bit 0 of v0 element i
- rf_status  out  2  `RF_NOP` / `RF_FINISHED`
- busy  out  1  pending write not yet committed

## Operation
- Reads: on each enabled edge, rs1/rs2/rs3 latched into index registers; rsN_data combinationally from latched index. mask_data always reflects v0.
- Accept: enabled edge with write_back_enabled=1. If rf_signal==`VECTOR_RF_WRITE`, element enable e_i = (start ≤ i < length) && (vm || v0[i*LEN]); pending vector = data where e_i, else current rd contents (including any pending write to rd). Pending valid set; busy=1.
- Null request (write_back_enabled=1, rf_signal≠write): pending valid set with no register change; still completes.
- Commit: edge after accept writes the full pending vector to rd; rf_status=`RF_FINISHED` after that edge for one cycle, else `RF_NOP`.
- Back-to-back accepts every cycle allowed; new accept and old commit share an edge. Same rd back-to-back: second merge sees first's result.
- v0 mask for accept uses v0 including a pending write to v0.
- length > VECTOR_SIZE clamps to VECTOR_SIZE; start ≥ length writes nothing but completes with `RF_FINISHED`.
- rd = 0 with vm=0 is legal; mask sampled before the write.

## Timing
- Read latency: index on edge N, data valid after edge N.
- Write: accept edge N, commit edge N+1, rf_status=`RF_FINISHED` during cycle N+1..N+2.
- rdy_in=0: indices, pending stage, array, rf_status held.
- Reset: all 32 registers = 0, index registers = 0 (outputs 0), pending invalid, busy=0, rf_status=`RF_NOP`. Reset with pending write discards it (no commit, no `RF_FINISHED`).

## Configuration
- VRF_BYPASS_EN defined: rsN_data and mask_data return pending vector when pending valid and index matches pending rd; no read hazard.
- Undefined: reads return array contents only; reads of rd return old data until commit; control must stall one cycle.

## Structure
- `VECTOR_RF_WRITE`, `RF_NOP`, `RF_FINISHED` stay in src/defines.v; add `VRF_NUM_REGS` (32) there.
- One sub-module: vrf_write_merge (combinational: old vector, data, start, length, vm, mask → merged vector); instantiated once for accept path.

## Test plan
- Reset then read rs1=5, rs2=31 -> both outputs 0, rf_status=`RF_NOP`, busy=0.
- Write rd=3, data element i = i+1, start=0, length=8, vm=1 -> `RF_FINISHED` one cycle after commit; read rs1=3 returns 1..8.
- v0 elements = 1,0,1,0,…; write rd=4 vm=0 start=1 length=6, data all 0xAA over zeroed v4 -> only elements 2,4 = 0xAA.
- Back-to-back writes rd=7 elements 0..3 = 0x11 then 4..7 = 0x22 -> v7 = four 0x11 then four 0x22; two `RF_FINISHED` cycles.
- With VRF_BYPASS_EN, read rd=7 on cycle after accept -> new data; without it -> old data.
- Assert rst with pending write to rd=9 -> v9 = 0, no `RF_FINISHED`; rdy_in=0 for 3 cycles mid-write -> commit delayed 3 cycles, data intact.
